dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the memory stage and backing memory in the cache CPU. It accepts one doubleword-aligned load or store at a time from the memory stage and returns raw 64-bit doubleword data. The memory stage still does byte selection and sign/zero extension. Misses refill a full line from backing memory as a burst. Stores are always forwarded downstream.

---
 rtl/dcache.sv | 191 +++++++++++++++++++
 tb/tb_dcache.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Ports: req_* from the memory stage, resp_* back to it, mem_rd_* line
// refill bursts, mem_wr_* write-through stores, hit_cnt/miss_cnt perf
// counters (present only when DCACHE_PERF_EN is defined, else constant 0).
module dcache #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        mem_rd_valid,
  input  logic        mem_rd_ready,
  output logic [63:0] mem_rd_addr,
  input  logic        mem_rd_dvalid,
  input  logic [63:0] mem_rd_data,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [63:0] mem_wr_addr,
  output logic [63:0] mem_wr_data,
  output logic [7:0]  mem_wr_strb,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WB   = $clog2(WORDS);
  localparam int IB   = $clog2(LINES);
  localparam int TAGW = 61 - WB - IB;
  localparam logic [WB-1:0] LAST = WB'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESP, WRITE
  } state_t;

  state_t state, state_nx;

  logic [63:3]     addr_q;
  logic            we_q;
  logic [63:0]     wdata_q;
  logic [7:0]      wstrb_q;
  logic [63:0]     beat_q;
  logic [WB-1:0]   cnt_q;
  logic [LINES-1:0] valid_q;

  logic [TAGW-1:0] tag_q  [LINES];
  logic [63:0]     data_q [LINES][WORDS];

  logic [WB-1:0]   word;
  logic [IB-1:0]   idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic [63:0]     cur;
  logic [63:0]     merged;
  logic            beat_in;
  logic            unused_ok;

  assign unused_ok = ^req_addr[2:0];

  assign word = addr_q[3+:WB];
  assign idx  = addr_q[3+WB+:IB];
  assign tag  = addr_q[63-:TAGW];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign cur  = data_q[idx][word];

  assign beat_in = (state == REFILL_DATA) && mem_rd_dvalid;

  always_comb begin
    merged = cur;
    for (int b = 0; b < 8; b++) begin
      if (wstrb_q[b]) merged[8*b+:8] = wdata_q[8*b+:8];
    end
  end

  assign mem_rd_addr = {addr_q[63:3+WB], {(WB+3){1'b0}}};
  assign mem_wr_addr = {addr_q, 3'b000};
  assign mem_wr_data = wdata_q;
  assign mem_wr_strb = wstrb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    mem_rd_valid = 1'b0;
    mem_wr_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = LOOKUP;
      end
      LOOKUP: begin
        if (we_q) begin
          state_nx = WRITE;
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = cur;
          state_nx   = IDLE;
        end else begin
          state_nx = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        mem_rd_valid = 1'b1;
        if (mem_rd_ready) state_nx = REFILL_DATA;
      end
      REFILL_DATA: begin
        if (mem_rd_dvalid && cnt_q == LAST) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = beat_q;
        state_nx   = IDLE;
      end
      WRITE: begin
        mem_wr_valid = 1'b1;
        if (mem_wr_ready) begin
          resp_valid = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr[63:3];
        we_q    <= req_we;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (state == REFILL_REQ) cnt_q <= '0;
      if (beat_in) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == word) beat_q <= mem_rd_data;
        if (cnt_q == LAST) valid_q[idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage needs no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    if (beat_in) begin
      data_q[idx][cnt_q] <= mem_rd_data;
      if (cnt_q == LAST) tag_q[idx] <= tag;
    end
    if (state == LOOKUP && we_q && hit) data_q[idx][word] <= merged;
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_q  <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: directed loads/stores with a scripted
// backing memory; a negedge monitor checks every resp_valid pulse.
module tb_dcache;
  localparam int LINES = 64;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        mem_rd_valid;
  logic        mem_rd_ready = 1'b0;
  logic [63:0] mem_rd_addr;
  logic        mem_rd_dvalid = 1'b0;
  logic [63:0] mem_rd_data = '0;
  logic        mem_wr_valid;
  logic        mem_wr_ready = 1'b0;
  logic [63:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_strb;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] beats[WORDS];
  bit perf;

  dcache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_dvalid(mem_rd_dvalid),
    .mem_rd_data(mem_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got %h expected none", resp_rdata);
      end else begin
        chk("resp_rdata", resp_rdata, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beats(input logic [63:0] b);
    for (int i = 0; i < WORDS; i++) beats[i] = b * 64'(i + 1);
  endtask

  task automatic counters(input logic [31:0] h, input logic [31:0] m);
    chk("hit_cnt", hit_cnt, perf ? h : 32'd0);
    chk("miss_cnt", miss_cnt, perf ? m : 32'd0);
  endtask

  // Leaves the bench #1 into cycle T+1 after acceptance edge T.
  task automatic issue(input logic we, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
  endtask

  task automatic load_hit(input logic [63:0] a, input logic [63:0] exp);
    sb.push_back(exp);
    issue(1'b0, a, '0, '0);
    chk("hit_resp_T1", resp_valid, 1);
    chk("hit_no_rd", mem_rd_valid, 0);
    tick();
    chk("hit_pulse_end", resp_valid, 0);
  endtask

  task automatic refill_start(input logic [63:0] a, input logic [63:0] la);
    issue(1'b0, a, '0, '0);
    chk("miss_lookup_no_rd", mem_rd_valid, 0);
    tick();
    chk("miss_rd_T2", mem_rd_valid, 1);
    chk("miss_rd_addr", mem_rd_addr, la);
    tick();
    chk("miss_rd_held", mem_rd_valid, 1);
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
  endtask

  task automatic load_miss(input logic [63:0] a, input logic [63:0] la,
                           input int w, input bit gap);
    sb.push_back(beats[w]);
    refill_start(a, la);
    for (int i = 0; i < WORDS; i++) begin
      mem_rd_dvalid = 1'b1;
      mem_rd_data   = beats[i];
      tick();
      mem_rd_dvalid = 1'b0;
      mem_rd_data   = '0;
      if (i != WORDS - 1) begin
        chk("refill_no_resp", resp_valid, 0);
        if (gap) tick();
      end
    end
    chk("miss_resp", resp_valid, 1);
    tick();
    chk("miss_pulse_end", resp_valid, 0);
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, input int delay);
    sb.push_back('0);
    issue(1'b1, a, d, s);
    chk("st_no_wr_T1", mem_wr_valid, 0);
    tick();
    for (int i = 0; i <= delay; i++) begin
      chk("st_wr_valid", mem_wr_valid, 1);
      chk("st_wr_addr", mem_wr_addr, {a[63:3], 3'b000});
      chk("st_wr_data", mem_wr_data, d);
      chk("st_wr_strb", mem_wr_strb, s);
      chk("st_no_rd", mem_rd_valid, 0);
      if (i < delay) begin
        chk("st_wait_no_resp", resp_valid, 0);
        tick();
      end
    end
    mem_wr_ready = 1'b1;
    #1;
    chk("st_resp_hs", resp_valid, 1);
    tick();
    mem_wr_ready = 1'b0;
    chk("st_idle", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
`ifdef DCACHE_PERF_EN
    perf = 1'b1;
`else
    perf = 1'b0;
`endif
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_rd_valid", mem_rd_valid, 0);
    chk("rst_wr_valid", mem_wr_valid, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_wr_strb", {56'd0, mem_wr_strb}, 0);
    counters(0, 0);
    rst = 1'b1;
    tick();

    set_beats(64'h11);
    load_miss(64'h8000_0010, 64'h8000_0000, 2, 1'b0);
    load_hit(64'h8000_0018, 64'h44);
    counters(1, 1);

    store(64'h8000_0010, 64'hAABB, 8'h03, 3);
    load_hit(64'h8000_0010, 64'hAABB);
    counters(3, 1);

    store(64'h9000_0000, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0);
    set_beats(64'h0500_0000_0000_0001);
    load_miss(64'h9000_0000, 64'h9000_0000, 0, 1'b1);
    counters(3, 3);

    set_beats(64'hA0);
    load_miss(64'h8000_0000, 64'h8000_0000, 0, 1'b0);
    set_beats(64'hB0);
    load_miss(64'h8000_0000 + 64'(8 * WORDS * LINES),
              64'h8000_0000 + 64'(8 * WORDS * LINES), 0, 1'b1);
    set_beats(64'hC0);
    load_miss(64'h8000_0008, 64'h8000_0000, 1, 1'b0);
    counters(3, 6);

    set_beats(64'hD0);
    refill_start(64'h8000_0020, 64'h8000_0020);
    for (int i = 0; i < 2; i++) begin
      mem_rd_dvalid = 1'b1;
      mem_rd_data   = beats[i];
      tick();
    end
    mem_rd_dvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rd_valid", mem_rd_valid, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_rd_addr", mem_rd_addr, 0);
    counters(0, 0);
    tick();
    rst = 1'b1;
    tick();

    set_beats(64'hE0);
    load_miss(64'h8000_0020, 64'h8000_0020, 0, 1'b0);
    set_beats(64'hF0);
    load_miss(64'h8000_0018, 64'h8000_0000, 3, 1'b1);
    counters(0, 2);

    tick();
    chk("sb_drained", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
